// File: rtl/key128_inv_exp_pkg.sv
// Shared state encoding and GF(2^8) / AES helper functions for the AES-128 inverse key scheduler.
package key128_inv_exp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LOAD = 3'b010,
        LODN = 3'b100
    } state_e;

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] m;
        p = '0;
        x = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = gf_mul2(x);
            m = m >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        return gf_mul(a, 8'h09);
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] a);
        return gf_mul(a, 8'h0b);
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] a);
        return gf_mul(a, 8'h0d);
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] a);
        return gf_mul(a, 8'h0e);
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), a);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[3:0], v[7:4]} ^ {v[4:0], v[7:5]} ^ {v[5:0], v[7:6]} ^ {v[6:0], v[7]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mixcol_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    function automatic logic [127:0] inv_mixcol(input logic [127:0] k);
        return {inv_mixcol_word(k[127:96]), inv_mixcol_word(k[95:64]),
                inv_mixcol_word(k[63:32]),  inv_mixcol_word(k[31:0])};
    endfunction

endpackage

// File: rtl/aes_sbox_reg.sv
// Registered AES S-box: one byte substitution with a single cycle of latency, load-enabled.
module aes_sbox_reg
    import key128_inv_exp_pkg::*;
(
    input  logic       clk_i,
    input  logic       en_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);

    logic [7:0] dout_q;

    always_ff @(posedge clk_i) begin
        if (en_i) dout_q <= sbox(din_i);
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/key128_inv_step.sv
// One backwards step of the AES-128 key schedule: previous round key from the current one.
module key128_inv_step (
    input  logic [127:0] key_i,
    input  logic [31:0]  sub_i,
    input  logic [7:0]   rcon_i,
    output logic [31:0]  t3_o,
    output logic [127:0] prev_o
);

    logic [31:0] c0, c1, c2, c3;

    assign {c0, c1, c2, c3} = key_i;
    assign t3_o = c3 ^ c2;

    // sub_i holds SubWord(t3) byte-aligned with t3; RotWord is applied here.
    assign prev_o = {c0 ^ {sub_i[23:0], sub_i[31:24]} ^ {rcon_i, 24'h0},
                     c1 ^ c0,
                     c2 ^ c1,
                     c3 ^ c2};

endmodule

// File: rtl/key128_inv_exp.sv
// AES-128 inverse key scheduler: emits round keys 10 down to 0 from the round-10 key.
// Build option KEY128_INVMIX_EN: counts 1..9 are output through InvMixColumns.
module key128_inv_exp
    import key128_inv_exp_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         mclk,
    input  logic         srst,
    input  logic [127:0] ck128_last,
    input  logic         start128,
    output logic [127:0] rk128_inv,
    output logic [3:0]   rk128_inv_count,
    output logic         rk128_inv_le,
    output logic         busy128_inv
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         sbox_en;
    logic [31:0]  t3;
    logic [31:0]  sub_w;
    logic [127:0] prev_key;

    always_ff @(posedge mclk) begin
        if (srst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        sbox_en      = 1'b0;
        rk128_inv_le = 1'b0;
        busy128_inv  = 1'b0;
        case (state_q)
            IDLE: begin
                busy128_inv = start128 & ~srst;
                if (start128) begin
                    state_d = LOAD;
                    key_d   = ck128_last;
                    cnt_d   = 4'(NR);
                end
            end
            LOAD: begin
                rk128_inv_le = 1'b1;
                busy128_inv  = 1'b1;
                if (cnt_q != 4'd0) begin
                    sbox_en = 1'b1;
                    state_d = LODN;
                end else begin
                    state_d = IDLE;
                end
            end
            LODN: begin
                busy128_inv = 1'b1;
                state_d     = LOAD;
                key_d       = prev_key;
                cnt_d       = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // SubWord(t3) is captured during LOAD and consumed during LODN.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_reg u_sbox (
            .clk_i  (mclk),
            .en_i   (sbox_en),
            .din_i  (t3[8*g +: 8]),
            .dout_o (sub_w[8*g +: 8])
        );
    end

    key128_inv_step u_step (
        .key_i  (key_q),
        .sub_i  (sub_w),
        .rcon_i (rcon(cnt_q)),
        .t3_o   (t3),
        .prev_o (prev_key)
    );

    assign rk128_inv_count = cnt_q;

`ifdef KEY128_INVMIX_EN
    assign rk128_inv = (cnt_q != 4'd0 && cnt_q != 4'(NR)) ? inv_mixcol(key_q) : key_q;
`else
    assign rk128_inv = key_q;
`endif

endmodule

// File: tb/tb_key128_inv_exp.sv
// Self-checking bench for key128_inv_exp: directed sequence plus forward-schedule scoreboard.
module tb_key128_inv_exp;

    logic         mclk = 1'b0;
    logic         srst;
    logic [127:0] ck128_last;
    logic         start128;
    logic [127:0] rk128_inv;
    logic [3:0]   rk128_inv_count;
    logic         rk128_inv_le;
    logic         busy128_inv;

    always #5 mclk = ~mclk;

    key128_inv_exp dut (
        .mclk            (mclk),
        .srst            (srst),
        .ck128_last      (ck128_last),
        .start128        (start128),
        .rk128_inv       (rk128_inv),
        .rk128_inv_count (rk128_inv_count),
        .rk128_inv_le    (rk128_inv_le),
        .busy128_inv     (busy128_inv)
    );

    typedef struct packed {
        logic [3:0]   cnt;
        logic [127:0] rk;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sb[256];
    logic [127:0] cap[11];
    bit           mon_en = 1'b0;
    logic [127:0] k10;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] k);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            {a0, a1, a2, a3} = k[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9),
                                   gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13),
                                   gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11),
                                   gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14)};
        end
        return r;
    endfunction

    // Forward key expansion, then queue the expected strobes in reverse order.
    task automatic push_run(input logic [127:0] k0, output logic [127:0] last);
        logic [127:0] r[11];
        logic [7:0]   rc;
        logic [31:0]  w0, w1, w2, w3, t;
        exp_t         e;
        r[0] = k0;
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            {w0, w1, w2, w3} = r[i-1];
            t  = subw({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            r[i] = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
        for (int c = 10; c >= 0; c--) begin
            e.cnt = 4'(c);
            e.rk  = r[c];
`ifdef KEY128_INVMIX_EN
            if (c >= 1 && c <= 9) e.rk = imc(r[c]);
`endif
            sbq.push_back(e);
        end
        last = r[10];
    endtask

    always @(negedge mclk) begin
        if (mon_en && rk128_inv_le === 1'b1) begin
            chk("strobe_expected", 128'(sbq.size() != 0), 128'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("count", 128'(rk128_inv_count), 128'(e.cnt));
                chk("rk", rk128_inv, e.rk);
                if (rk128_inv_count <= 4'd10) cap[rk128_inv_count] = rk128_inv;
            end
        end
    end

    task automatic wait_strobe(input int cnt);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge mclk);
            if (rk128_inv_le === 1'b1 && rk128_inv_count === 4'(cnt)) found = 1'b1;
        end
        chk("wait_strobe", 128'(found), 128'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge mclk);
            if (busy128_inv === 1'b0) idle = 1'b1;
        end
        chk("wait_idle", 128'(idle), 128'd1);
    endtask

    task automatic pulse_start(input logic [127:0] key);
        @(posedge mclk); #1;
        ck128_last = key;
        start128   = 1'b1;
        @(posedge mclk); #1;
        start128   = 1'b0;
    endtask

    initial begin
        srst       = 1'b1;
        start128   = 1'b0;
        ck128_last = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        chk("rst_rk", rk128_inv, 128'd0);
        chk("rst_cnt", 128'(rk128_inv_count), 128'd0);
        chk("rst_le", 128'(rk128_inv_le), 128'd0);
        chk("rst_busy", 128'(busy128_inv), 128'd0);
        @(posedge mclk); #1;
        srst   = 1'b0;
        mon_en = 1'b1;

        // Known FIPS-197 vector with cycle-exact strobe/busy timing.
        push_run(128'h2b7e151628aed2a6abf7158809cf4f3c, k10);
        ck128_last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        start128   = 1'b1;
        @(negedge mclk);
        chk("busy_start", 128'(busy128_inv), 128'd1);
        @(posedge mclk); #1;
        start128 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge mclk);
            chk("timing_le", 128'(rk128_inv_le), 128'((k % 2 == 1) && (k <= 21)));
            chk("timing_busy", 128'(busy128_inv), 128'(k <= 21));
        end
        chk("key10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifndef KEY128_INVMIX_EN
        chk("key9", cap[9], 128'hac7766f319fadc2128d12941575c006e);
`endif
        chk("key0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("sb_empty_1", 128'(sbq.size()), 128'd0);

        // start128 pulses mid-sequence are ignored.
        push_run(128'h2b7e151628aed2a6abf7158809cf4f3c, k10);
        pulse_start(k10);
        wait_strobe(7);
        ck128_last = 128'h00112233445566778899aabbccddeeff;
        start128   = 1'b1;
        @(negedge mclk);
        start128   = 1'b0;
        wait_strobe(3);
        start128   = 1'b1;
        @(negedge mclk);
        start128   = 1'b0;
        wait_idle();
        chk("sb_empty_3", 128'(sbq.size()), 128'd0);

        // Synchronous reset mid-sequence, then a clean restart.
        push_run(128'h000102030405060708090a0b0c0d0e0f, k10);
        pulse_start(k10);
        wait_strobe(6);
        srst = 1'b1;
        @(negedge mclk);
        chk("srst_le", 128'(rk128_inv_le), 128'd0);
        chk("srst_busy", 128'(busy128_inv), 128'd0);
        chk("srst_cnt", 128'(rk128_inv_count), 128'd0);
        chk("srst_rk", rk128_inv, 128'd0);
        srst = 1'b0;
        chk("srst_left", 128'(sbq.size()), 128'd6);
        sbq.delete();
        push_run(128'hffeeddccbbaa99887766554433221100, k10);
        pulse_start(k10);
        wait_idle();
        chk("restart_cnt10", cap[10], k10);
        chk("sb_empty_4", 128'(sbq.size()), 128'd0);

        // start128 held high: three back-to-back runs.
        for (int r = 0; r < 3; r++) push_run(128'h3c4fcf098815f7aba6d2ae2816157e2b, k10);
        @(posedge mclk); #1;
        ck128_last = k10;
        start128   = 1'b1;
        for (int i = 0; i <= 50; i++) begin
            @(negedge mclk);
            chk("held_busy", 128'(busy128_inv), 128'd1);
            chk("held_le", 128'(rk128_inv_le), 128'((i >= 1) && ((i - 1) % 2 == 0)));
        end
        start128 = 1'b0;
        wait_idle();
        chk("sb_empty_5", 128'(sbq.size()), 128'd0);

        // Random keys through the forward model.
        for (int n = 0; n < 200; n++) begin
            push_run({$urandom, $urandom, $urandom, $urandom}, k10);
            pulse_start(k10);
            wait_idle();
        end
        chk("sb_empty_6", 128'(sbq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
